// File: rtl/spec_free_list.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spec_free_list: speculative physical-tag free list, 4 pops/4 pushes per  |
// | cycle, one-cycle refill to full on recovery.                             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spec_free_list #(
  parameter int PHYS_REGS = 96,
  parameter int ARCH_REGS = 32,
  parameter int PHYS_LOG  = 7,
  parameter int DEPTH     = PHYS_REGS - ARCH_REGS,
  parameter int DEPTH_LOG = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reqValid0_i,
  input  logic                 reqValid1_i,
  input  logic                 reqValid2_i,
  input  logic                 reqValid3_i,
  output logic [PHYS_LOG-1:0]  freePhyReg0_o,
  output logic [PHYS_LOG-1:0]  freePhyReg1_o,
  output logic [PHYS_LOG-1:0]  freePhyReg2_o,
  output logic [PHYS_LOG-1:0]  freePhyReg3_o,
  output logic                 freeListEmpty_o,
  input  logic                 releasedValid0_i,
  input  logic                 releasedValid1_i,
  input  logic                 releasedValid2_i,
  input  logic                 releasedValid3_i,
  input  logic [PHYS_LOG-1:0]  releasedPhyMap0_i,
  input  logic [PHYS_LOG-1:0]  releasedPhyMap1_i,
  input  logic [PHYS_LOG-1:0]  releasedPhyMap2_i,
  input  logic [PHYS_LOG-1:0]  releasedPhyMap3_i,
  input  logic                 recoverFlag_i,
  output logic [DEPTH_LOG:0]   freeCount_o,
  output logic                 overflow_o
);

  localparam int c_SLOTS = 4;

  logic [PHYS_LOG-1:0]  r_entry [DEPTH];
  logic [DEPTH_LOG-1:0] r_headPtr;
  logic [DEPTH_LOG-1:0] r_tailPtr;
  logic [DEPTH_LOG:0]   r_count;
  logic                 r_overflow;

  logic [c_SLOTS-1:0]   w_req;
  logic [c_SLOTS-1:0]   w_relValid;
  logic [PHYS_LOG-1:0]  w_relTag   [c_SLOTS];
  logic [DEPTH_LOG-1:0] w_readIdx  [c_SLOTS];
  logic [DEPTH_LOG-1:0] w_writeIdx [c_SLOTS];
  logic [c_SLOTS-1:0]   w_writeEn;
  logic [2:0]           w_reqCnt;
  logic [2:0]           w_popCnt;
  logic [2:0]           w_pushReq;
  logic [2:0]           w_pushCnt;
  logic [DEPTH_LOG:0]   w_room;
  logic [DEPTH_LOG-1:0] w_tailNext;
  logic                 w_empty;
  logic                 w_ovfNow;

  assign w_req      = {reqValid3_i, reqValid2_i, reqValid1_i, reqValid0_i};
  assign w_relValid = {releasedValid3_i, releasedValid2_i, releasedValid1_i, releasedValid0_i};
  assign w_relTag[0] = releasedPhyMap0_i;
  assign w_relTag[1] = releasedPhyMap1_i;
  assign w_relTag[2] = releasedPhyMap2_i;
  assign w_relTag[3] = releasedPhyMap3_i;

  always_comb begin
    w_empty    = r_count < (DEPTH_LOG+1)'(c_SLOTS);
    w_reqCnt   = '0;
    w_pushReq  = '0;
    w_pushCnt  = '0;
    w_writeEn  = '0;
    for (int k = 0; k < c_SLOTS; k++) begin
      w_readIdx[k] = r_headPtr + DEPTH_LOG'(w_reqCnt);
      w_reqCnt     = w_reqCnt + 3'(w_req[k]);
    end
    // Recovery rebuilds the head from the tail, so no tag is consumed that cycle.
    w_popCnt = (w_empty || recoverFlag_i) ? 3'd0 : w_reqCnt;
    w_room   = (DEPTH_LOG+1)'(DEPTH) - r_count + (DEPTH_LOG+1)'(w_popCnt);
    for (int k = 0; k < c_SLOTS; k++) begin
      w_writeIdx[k] = r_tailPtr + DEPTH_LOG'(w_pushCnt);
      if (w_relValid[k]) begin
        if ((DEPTH_LOG+1)'(w_pushReq) < w_room) begin
          w_writeEn[k] = 1'b1;
          w_pushCnt    = w_pushCnt + 3'd1;
        end
        w_pushReq = w_pushReq + 3'd1;
      end
    end
    w_ovfNow   = (w_pushReq != w_pushCnt);
    w_tailNext = r_tailPtr + DEPTH_LOG'(w_pushCnt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= PHYS_LOG'(ARCH_REGS + i);
      end
      r_headPtr  <= '0;
      r_tailPtr  <= '0;
      r_count    <= (DEPTH_LOG+1)'(DEPTH);
      r_overflow <= 1'b0;
    end else begin
      for (int k = 0; k < c_SLOTS; k++) begin
        if (w_writeEn[k]) begin
          r_entry[w_writeIdx[k]] <= w_relTag[k];
        end
      end
      r_tailPtr <= w_tailNext;
      if (recoverFlag_i) begin
        r_headPtr <= w_tailNext;
        r_count   <= (DEPTH_LOG+1)'(DEPTH);
      end else begin
        r_headPtr <= r_headPtr + DEPTH_LOG'(w_popCnt);
        r_count   <= r_count + (DEPTH_LOG+1)'(w_pushCnt) - (DEPTH_LOG+1)'(w_popCnt);
      end
      if (w_ovfNow) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign freePhyReg0_o   = r_entry[w_readIdx[0]];
  assign freePhyReg1_o   = r_entry[w_readIdx[1]];
  assign freePhyReg2_o   = r_entry[w_readIdx[2]];
  assign freePhyReg3_o   = r_entry[w_readIdx[3]];
  assign freeListEmpty_o = w_empty;
  assign freeCount_o     = r_count;
  assign overflow_o      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_spec_free_list.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spec_free_list: randomized scoreboard bench against a rotating-queue  |
// | model of the free list.                                                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_spec_free_list;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] relV;
  logic [6:0] relTag [4];
  logic       recover;
  logic [6:0] dutTag [4];
  logic       dutEmpty;
  logic [6:0] dutCount;
  logic       dutOvf;

  always #5 clk = ~clk;

  spec_free_list dut (
    .clk               (clk),
    .reset             (reset),
    .reqValid0_i       (req[0]),
    .reqValid1_i       (req[1]),
    .reqValid2_i       (req[2]),
    .reqValid3_i       (req[3]),
    .freePhyReg0_o     (dutTag[0]),
    .freePhyReg1_o     (dutTag[1]),
    .freePhyReg2_o     (dutTag[2]),
    .freePhyReg3_o     (dutTag[3]),
    .freeListEmpty_o   (dutEmpty),
    .releasedValid0_i  (relV[0]),
    .releasedValid1_i  (relV[1]),
    .releasedValid2_i  (relV[2]),
    .releasedValid3_i  (relV[3]),
    .releasedPhyMap0_i (relTag[0]),
    .releasedPhyMap1_i (relTag[1]),
    .releasedPhyMap2_i (relTag[2]),
    .releasedPhyMap3_i (relTag[3]),
    .recoverFlag_i     (recover),
    .freeCount_o       (dutCount),
    .overflow_o        (dutOvf)
  );

  typedef struct packed {
    logic [6:0]      cnt;
    logic            empty;
    logic            ovf;
    logic [3:0]      mask;
    logic [3:0][6:0] tags;
  } exp_t;

  exp_t sb[$];
  exp_t monE;
  int   ring[$];   // whole ring starting at head; first mCnt entries are free
  int   mCnt;
  bit   mOvf;
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    ring.delete();
    for (int i = 0; i < DEPTH; i++) ring.push_back(32 + i);
    mCnt = DEPTH;
    mOvf = 1'b0;
  endtask

  task automatic expect_now();
    exp_t e;
    int   r = 0;
    e.cnt   = 7'(mCnt);
    e.empty = (mCnt < 4);
    e.ovf   = mOvf;
    e.mask  = '0;
    e.tags  = '0;
    for (int k = 0; k < 4; k++) begin
      if (req[k] && !e.empty) begin
        e.mask[k] = 1'b1;
        e.tags[k] = 7'(ring[r]);
        r++;
      end
    end
    sb.push_back(e);
  endtask

  task automatic model_step();
    int pops, room, tmp;
    int acc = 0;
    pops = (mCnt < 4 || recover) ? 0 : $countones(req);
    repeat (pops) begin tmp = ring.pop_front(); ring.push_back(tmp); end
    mCnt -= pops;
    room = DEPTH - mCnt;
    for (int k = 0; k < 4; k++) begin
      if (relV[k]) begin
        if (acc < room) begin
          ring[mCnt + acc] = int'(relTag[k]);
          acc++;
        end else begin
          mOvf = 1'b1;
        end
      end
    end
    mCnt += acc;
    if (recover) begin
      repeat (mCnt) begin tmp = ring.pop_front(); ring.push_back(tmp); end
      mCnt = DEPTH;
    end
  endtask

  task automatic cycle(input logic [3:0] rq, input logic [3:0] rv,
                       input int t0, input int t1, input int t2, input int t3,
                       input logic rc);
    req = rq; relV = rv; recover = rc;
    relTag[0] = 7'(t0); relTag[1] = 7'(t1); relTag[2] = 7'(t2); relTag[3] = 7'(t3);
    expect_now();
    model_step();
    @(posedge clk); #1;
  endtask

  // Asserted between clock edges; the monitor samples before any edge arrives.
  task automatic do_reset();
    req = '0; relV = '0; recover = 1'b0;
    reset = 1'b0;
    model_reset();
    expect_now();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      monE = sb.pop_front();
      chk("freeCount", int'(dutCount), int'(monE.cnt));
      chk("empty", int'(dutEmpty), int'(monE.empty));
      chk("overflow", int'(dutOvf), int'(monE.ovf));
      for (int k = 0; k < 4; k++) begin
        if (monE.mask[k]) chk($sformatf("tag slot%0d", k), int'(dutTag[k]), int'(monE.tags[k]));
      end
    end
  end

  initial begin
    reset = 1'b0; req = '0; relV = '0; recover = 1'b0;
    for (int k = 0; k < 4; k++) relTag[k] = '0;
    model_reset();
    @(posedge clk); #1;

    do_reset();
    cycle(4'b1111, 4'b0000, 0, 0, 0, 0, 1'b0);
    do_reset();
    cycle(4'b1011, 4'b0000, 0, 0, 0, 0, 1'b0);
    cycle(4'b0001, 4'b0000, 0, 0, 0, 0, 1'b0);

    // Drain to empty, then requests are ignored; refill and pop again.
    do_reset();
    repeat (18) cycle(4'b1111, 4'b0000, 0, 0, 0, 0, 1'b0);
    cycle(4'b0000, 4'b1111, 40, 41, 42, 43, 1'b0);
    cycle(4'b1111, 4'b0000, 0, 0, 0, 0, 1'b0);
    cycle(4'b1111, 4'b0000, 0, 0, 0, 0, 1'b0);

    // Holey push while popping, then run the head around the wrap.
    do_reset();
    cycle(4'b1111, 4'b0000, 0, 0, 0, 0, 1'b0);
    cycle(4'b1111, 4'b0101, 5, 0, 9, 0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(4'b1111, 4'b1111, 60 + i, 10 + i, 20 + i, 90, 1'b0);

    // Recovery with same-cycle releases, then back-to-back recoveries.
    do_reset();
    cycle(4'b1111, 4'b0000, 0, 0, 0, 0, 1'b0);
    cycle(4'b1111, 4'b0000, 0, 0, 0, 0, 1'b0);
    cycle(4'b0011, 4'b0000, 0, 0, 0, 0, 1'b0);
    cycle(4'b1111, 4'b0011, 7, 8, 0, 0, 1'b1);
    cycle(4'b0001, 4'b0000, 0, 0, 0, 0, 1'b0);
    cycle(4'b1111, 4'b0000, 0, 0, 0, 0, 1'b1);
    cycle(4'b0000, 4'b0000, 0, 0, 0, 0, 1'b1);
    cycle(4'b1111, 4'b0000, 0, 0, 0, 0, 1'b0);

    // Push into a full list.
    do_reset();
    cycle(4'b0000, 4'b0001, 3, 0, 0, 0, 1'b0);
    cycle(4'b1111, 4'b0000, 0, 0, 0, 0, 1'b0);
    cycle(4'b0000, 4'b0000, 0, 0, 0, 0, 1'b0);

    // Randomized traffic with occasional recovery and mid-run async reset.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) begin
        do_reset();
      end else begin
        cycle(4'($urandom), 4'($urandom),
              int'($urandom_range(0, 95)), int'($urandom_range(0, 95)),
              int'($urandom_range(0, 95)), int'($urandom_range(0, 95)),
              ($urandom_range(0, 24) == 0));
      end
    end
    cycle(4'b0000, 4'b0000, 0, 0, 0, 0, 1'b0);

    @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
